// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a one-entry holding register.
//
// Ports:
//   clk        single clock, all state updates on its rising edge
//   rst_n      asynchronous active-low reset
//   rxd        asynchronous serial line, idle high, LSB first
//   rx_data    received byte, valid while rx_valid=1
//   rx_valid   holding register full
//   rx_ready   consumer takes the byte when rx_valid & rx_ready at a rising edge
//   frame_err  one-cycle pulse when the stop bit is sampled low
//   overrun    one-cycle pulse when a completed byte is dropped
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 469
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StWaitHigh
    } state_e;

    state_e          state_q;
    logic            sync1_q;
    logic            rxs_q;
    logic [CntW-1:0] cnt_q;
    logic [2:0]      bit_q;
    logic [7:0]      shift_q;

    // Two-flop synchronizer; resets to the idle line level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            rxs_q   <= 1'b1;
        end else begin
            sync1_q <= rxd;
            rxs_q   <= sync1_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            // A delivery later in this block overrides this clear.
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end

            unique case (state_q)
                StIdle: begin
                    if (!rxs_q) begin
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        state_q <= StStart;
                    end
                end
                StStart: begin
                    // Mid start bit: still low means a real start, high means a glitch.
                    if (cnt_q == HalfLast) begin
                        cnt_q   <= '0;
                        state_q <= rxs_q ? StIdle : StData;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StData: begin
                    if (cnt_q == BitLast) begin
                        cnt_q   <= '0;
                        shift_q <= {rxs_q, shift_q[7:1]};
                        bit_q   <= bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            state_q <= StStop;
                        end
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StStop: begin
                    if (cnt_q == BitLast) begin
                        cnt_q <= '0;
                        if (rxs_q) begin
                            state_q <= StIdle;
                            // Free slot, or slot being emptied this same edge.
                            if (!rx_valid || rx_ready) begin
                                rx_data  <= shift_q;
                                rx_valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            frame_err <= 1'b1;
                            state_q   <= StWaitHigh;
                        end
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StWaitHigh: begin
                    // Break/stuck-low line: wait for idle before hunting for a start.
                    if (rxs_q) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx with CLKS_PER_BIT=16: table of frames plus hand-written
// corner sequences; delivered bytes are checked against a scoreboard queue.
module tb_uart_rx;

    localparam int unsigned CPB = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rxd;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rxd       (rxd),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;
    logic [7:0] exp_q[$];
    int valid_cycles     = 0;
    int valid_low_cycles = 0;
    int ferr_cycles      = 0;
    int ovr_cycles       = 0;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         exp_valid;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: sample mid-cycle, pop the scoreboard on each handshake.
    always @(negedge clk) begin
        if (rx_valid) valid_cycles++;
        else valid_low_cycles++;
        if (frame_err) ferr_cycles++;
        if (overrun) ovr_cycles++;
        if (rx_valid && rx_ready) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_byte: got %0h, expected none", rx_data);
            end else begin
                check("rx_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    // Called just after a rising edge; each bit lasts exactly CPB cycles.
    task automatic send_frame(input logic [7:0] d, input logic stop);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rxd = bits[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        valid_cycles = 0;
        ferr_cycles  = 0;
        ovr_cycles   = 0;
    endtask

    initial begin
        vecs[0] = '{data: 8'h55, stop: 1'b1, exp_valid: 1, exp_ferr: 0};
        vecs[1] = '{data: 8'hA3, stop: 1'b1, exp_valid: 1, exp_ferr: 0};
        vecs[2] = '{data: 8'h00, stop: 1'b1, exp_valid: 1, exp_ferr: 0};
        vecs[3] = '{data: 8'hFF, stop: 1'b1, exp_valid: 1, exp_ferr: 0};
        vecs[4] = '{data: 8'h3C, stop: 1'b0, exp_valid: 0, exp_ferr: 1};

        rst_n    = 1'b0;
        rxd      = 1'b1;
        rx_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_rx_data", {24'd0, rx_data}, 32'h0);
        check("reset_rx_valid", {31'd0, rx_valid}, 32'h0);
        check("reset_frame_err", {31'd0, frame_err}, 32'h0);
        check("reset_overrun", {31'd0, overrun}, 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(4);

        // Table of single frames with rx_ready held high.
        for (int i = 0; i < 5; i++) begin
            clear_counts();
            if (vecs[i].stop) exp_q.push_back(vecs[i].data);
            send_frame(vecs[i].data, vecs[i].stop);
            rxd = 1'b1;
            idle(2 * CPB);
            check($sformatf("vec%0d_valid_cycles", i), valid_cycles, vecs[i].exp_valid);
            check($sformatf("vec%0d_frame_err", i), ferr_cycles, vecs[i].exp_ferr);
            check($sformatf("vec%0d_overrun", i), ovr_cycles, 0);
        end

        // Short low glitch is rejected at the mid-start sample.
        clear_counts();
        rxd = 1'b0;
        idle(4);
        rxd = 1'b1;
        idle(2 * CPB);
        check("glitch_valid", valid_cycles, 0);
        check("glitch_frame_err", ferr_cycles, 0);
        clear_counts();
        exp_q.push_back(8'hA3);
        send_frame(8'hA3, 1'b1);
        idle(2 * CPB);
        check("after_glitch_valid", valid_cycles, 1);

        // Framing error followed by a long low line.
        clear_counts();
        send_frame(8'h3C, 1'b0);
        idle(40);
        rxd = 1'b1;
        idle(2 * CPB);
        check("break_frame_err", ferr_cycles, 1);
        check("break_valid", valid_cycles, 0);
        clear_counts();
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1);
        idle(2 * CPB);
        check("after_break_valid", valid_cycles, 1);
        check("after_break_frame_err", ferr_cycles, 0);

        // Overrun: second byte dropped while first is held.
        rx_ready = 1'b0;
        clear_counts();
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        idle(2 * CPB);
        @(negedge clk);
        check("ovr_pulses", ovr_cycles, 1);
        check("ovr_held_valid", {31'd0, rx_valid}, 32'h1);
        check("ovr_held_data", {24'd0, rx_data}, 32'h11);
        @(posedge clk);
        #1 rx_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("ovr_valid_falls", {31'd0, rx_valid}, 32'h0);
        idle(2);

        // Accept in the exact delivery cycle: stop sample lands 155 edges after
        // the start bit is driven (2 sync + 1 detect + 8 half + 144 bits).
        rx_ready = 1'b0;
        clear_counts();
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        idle(2 * CPB);
        exp_q.push_back(8'h22);
        valid_low_cycles = 0;
        fork
            send_frame(8'h22, 1'b1);
            begin
                repeat (154) @(posedge clk);
                #1 rx_ready = 1'b1;
                @(posedge clk);
                #1 rx_ready = 1'b0;
            end
        join
        @(negedge clk);
        check("same_cycle_valid", {31'd0, rx_valid}, 32'h1);
        check("same_cycle_data", {24'd0, rx_data}, 32'h22);
        check("same_cycle_overrun", ovr_cycles, 0);
        check("same_cycle_no_dip", valid_low_cycles, 0);
        @(posedge clk);
        #1 rx_ready = 1'b1;
        idle(4);

        // Reset during data bit 4 of 0xFF aborts the frame.
        clear_counts();
        fork
            send_frame(8'hFF, 1'b1);
            begin
                repeat (85) @(posedge clk);
                #1 rst_n = 1'b0;
                @(negedge clk);
                check("midreset_rx_data", {24'd0, rx_data}, 32'h0);
                check("midreset_rx_valid", {31'd0, rx_valid}, 32'h0);
                check("midreset_frame_err", {31'd0, frame_err}, 32'h0);
                check("midreset_overrun", {31'd0, overrun}, 32'h0);
                repeat (3) @(posedge clk);
                #1 rst_n = 1'b1;
            end
        join
        idle(2 * CPB);
        check("midreset_no_valid", valid_cycles, 0);
        check("midreset_no_ferr", ferr_cycles, 0);
        clear_counts();
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1);
        idle(2 * CPB);
        check("after_reset_valid", valid_cycles, 1);
        check("after_reset_ferr", ferr_cycles, 0);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
